// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: turns one load/store into one or two aligned, byte-enabled word accesses (build option LSU_MISALIGN_EN).
// Latency: resp_valid 2 cycles after accept (one word), 3 (word-spanning, LSU_MISALIGN_EN), 1 (rejected spanning access otherwise).
// Backpressure: req_ready is low for the whole access; responses cannot be stalled.
module lsu_mem_initiator #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic [31:0]           mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [3:0]            mem_wr,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int WI_W = DM_ADDRESS - 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
`ifdef LSU_MISALIGN_EN
        S_ACC1 = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [1:0]          off_q, off_d;
    logic [WI_W-1:0]     word_q, word_d;
    logic [7:0]          mask_q, mask_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
`ifdef LSU_MISALIGN_EN
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [WI_W-1:0]     word1;
`endif

    logic [3:0]          size_mask;
    logic [7:0]          req_mask;
    logic                span_q;
    logic                acc_err;
    logic [2*DATA_W-1:0] wide_wdata;
    logic [2*DATA_W-1:0] merged;
    logic [DATA_W-1:0]   aligned;
    logic [DATA_W-1:0]   load_ext;
    logic [DATA_W-1:0]   result;

    // Lane mask of the incoming request across the word pair {word+1, word}
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        req_mask = {4'b0000, size_mask} << req_addr[1:0];
    end

    assign span_q     = |mask_q[7:4];
    assign wide_wdata = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
`ifdef LSU_MISALIGN_EN
    assign acc_err = 1'b0;
    assign word1   = word_q + WI_W'(1);
`else
    assign acc_err = span_q;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: IDLE -> ACC0 [-> ACC1] -> DONE -> IDLE; rejected spans jump to DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
`ifdef LSU_MISALIGN_EN
                    state_d = S_ACC0;
`else
                    state_d = (|req_mask[7:4]) ? S_DONE : S_ACC0;
`endif
                end
            end
            S_ACC0: begin
`ifdef LSU_MISALIGN_EN
                state_d = span_q ? S_ACC1 : S_DONE;
`else
                state_d = S_DONE;
`endif
            end
`ifdef LSU_MISALIGN_EN
            S_ACC1:  state_d = S_DONE;
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch on accept, first-word read capture, response hold register
    always_comb begin
        we_d         = we_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        word_d       = word_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        resp_rdata_d = resp_rdata_q;
        if (state_q == S_IDLE && req_valid) begin
            we_d     = req_we;
            funct3_d = req_funct3;
            off_d    = req_addr[1:0];
            word_d   = req_addr[DM_ADDRESS-1:2];
            mask_d   = req_mask;
            wdata_d  = req_wdata;
        end
        if (state_q == S_DONE) resp_rdata_d = result;
    end

`ifdef LSU_MISALIGN_EN
    // Word 0 of a split load arrives during ACC1
    always_comb begin
        rdata0_d = rdata0_q;
        if (state_q == S_ACC1) rdata0_d = mem_rdata;
    end

    // First-word read data register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata0_q <= '0;
        else        rdata0_q <= rdata0_d;
    end
`endif

    // Request and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q         <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 2'b00;
            word_q       <= '0;
            mask_q       <= 8'h00;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
        end else begin
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            word_q       <= word_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Load result: merge words, shift the addressed byte to lane 0, truncate and extend
    always_comb begin
        merged = {{DATA_W{1'b0}}, mem_rdata};
`ifdef LSU_MISALIGN_EN
        if (span_q) merged = {mem_rdata, rdata0_q};
`endif
        aligned = DATA_W'(merged >> {off_q, 3'b000});
        case (funct3_q[1:0])
            2'b00:   load_ext = {{(DATA_W-8){aligned[7] & ~funct3_q[2]}}, aligned[7:0]};
            2'b01:   load_ext = {{(DATA_W-16){aligned[15] & ~funct3_q[2]}}, aligned[15:0]};
            default: load_ext = aligned;
        endcase
        result = (we_q || acc_err) ? '0 : load_ext;
    end

    // Outputs decoded from state; memory port is quiet outside the access states
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_DONE);
        resp_err   = 1'b0;
        resp_rdata = resp_rdata_q;
        mem_addr   = 32'h0;
        mem_wdata  = '0;
        mem_wr     = 4'b0000;
        case (state_q)
            S_ACC0: begin
                mem_addr  = {{(32-DM_ADDRESS){1'b0}}, word_q, 2'b00};
                mem_wdata = DATA_W'(wide_wdata);
                mem_wr    = we_q ? mask_q[3:0] : 4'b0000;
            end
`ifdef LSU_MISALIGN_EN
            S_ACC1: begin
                mem_addr  = {{(32-DM_ADDRESS){1'b0}}, word1, 2'b00};
                mem_wdata = DATA_W'(wide_wdata >> DATA_W);
                mem_wr    = we_q ? mask_q[7:4] : 4'b0000;
            end
`endif
            S_DONE: begin
                resp_err   = acc_err;
                resp_rdata = result;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: drives lsu_mem_initiator against a byte-array data memory.
// Directed vector table, hand sequences for split/wrap/reset cases, then random traffic vs a byte-level model.
// Expected values come from constants or the model; both build variants of LSU_MISALIGN_EN are handled.
module tb_lsu_mem_initiator;
`ifdef LSU_MISALIGN_EN
    localparam bit MISALIGN = 1'b1;
`else
    localparam bit MISALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [8:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wr;

    lsu_mem_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Data memory device: byte lanes written on the edge, read data one cycle after the address
    logic [7:0] dev_mem [512];
    logic       dev_clear;
    always @(posedge clk) begin
        if (dev_clear) begin
            for (int i = 0; i < 512; i++) dev_mem[i] <= 8'h00;
            mem_rdata <= 32'h0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_wr[i]) dev_mem[{mem_addr[8:2], 2'(i)}] <= mem_wdata[8*i +: 8];
            mem_rdata <= {dev_mem[{mem_addr[8:2], 2'd3}], dev_mem[{mem_addr[8:2], 2'd2}],
                          dev_mem[{mem_addr[8:2], 2'd1}], dev_mem[{mem_addr[8:2], 2'd0}]};
        end
    end

    logic [7:0]  ref_mem [512];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  wr_log   [4];
    logic [31:0] addr_log [4];
    logic [31:0] wdat_log [4];
    logic [31:0] d_rd, m_rd;
    logic        d_er, m_er;
    int          d_lat, m_lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory with wraparound; accesses crossing a word either split or are rejected
    task automatic model(input logic we, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        int sz, off;
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            default:        sz = 4;
        endcase
        off = int'(addr) % 4;
        rd  = 32'h0;
        er  = 1'b0;
        if (off + sz > 4 && !MISALIGN) begin
            er  = 1'b1;
            lat = 1;
            return;
        end
        lat = (off + sz > 4) ? 3 : 2;
        if (we) begin
            for (int k = 0; k < sz; k++) ref_mem[(int'(addr) + k) % 512] = wd[8*k +: 8];
        end else begin
            v = 32'h0;
            for (int k = 0; k < sz; k++) v[8*k +: 8] = ref_mem[(int'(addr) + k) % 512];
            if ((f3 == 3'b000 || f3 == 3'b001) && v[8*sz-1])
                for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
            rd = v;
        end
    endtask

    // One request: wait for the response (bounded), log memory-port activity per cycle after accept
    task automatic xact(input logic we, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wd);
        int   cyc;
        logic got, busy_bad;
        for (int i = 0; i < 4; i++) begin
            wr_log[i] = 4'h0; addr_log[i] = 32'h0; wdat_log[i] = 32'h0;
        end
        @(negedge clk);
        check("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        cyc = 0; got = 1'b0; busy_bad = 1'b0;
        d_rd = 32'h0; d_er = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            req_valid = 1'b0;
            if (req_ready) busy_bad = 1'b1;
            if (cyc < 4) begin
                wr_log[cyc] = mem_wr; addr_log[cyc] = mem_addr; wdat_log[cyc] = mem_wdata;
            end
            if (resp_valid) begin
                got = 1'b1; d_rd = resp_rdata; d_er = resp_err;
            end
        end
        check("resp_within_bound", {31'h0, got}, 32'h1);
        check("ready_low_while_busy", {31'h0, busy_bad}, 32'h0);
        d_lat = got ? cyc : -1;
        model(we, f3, addr, wd, m_rd, m_er, m_lat);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_wr;
        logic [31:0] exp_maddr;
        logic [31:0] exp_wdat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        int   rs_cyc, mism;
        logic [8:0]  rs_addr;
        logic [3:0]  rs_wr;
        logic [31:0] rs_maddr, rs_exp;
        logic        seen;
        logic        r_we;
        logic [2:0]  r_f3;
        logic [8:0]  r_addr;

        vecs[0]  = '{1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h00000000, 4'b1111, 32'h010, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 4'b0000, 32'h010, 32'h0};
        vecs[2]  = '{1'b1, 3'b000, 9'h013, 32'h000000A5, 32'h00000000, 4'b1000, 32'h010, 32'hA5000000};
        vecs[3]  = '{1'b0, 3'b000, 9'h013, 32'h0,        32'hFFFFFFA5, 4'b0000, 32'h010, 32'h0};
        vecs[4]  = '{1'b0, 3'b100, 9'h013, 32'h0,        32'h000000A5, 4'b0000, 32'h010, 32'h0};
        vecs[5]  = '{1'b1, 3'b001, 9'h012, 32'h00008001, 32'h00000000, 4'b1100, 32'h010, 32'h80010000};
        vecs[6]  = '{1'b0, 3'b001, 9'h012, 32'h0,        32'hFFFF8001, 4'b0000, 32'h010, 32'h0};
        vecs[7]  = '{1'b0, 3'b101, 9'h012, 32'h0,        32'h00008001, 4'b0000, 32'h010, 32'h0};
        vecs[8]  = '{1'b0, 3'b010, 9'h010, 32'h0,        32'h8001BEEF, 4'b0000, 32'h010, 32'h0};
        vecs[9]  = '{1'b0, 3'b011, 9'h010, 32'h0,        32'h8001BEEF, 4'b0000, 32'h010, 32'h0};
        vecs[10] = '{1'b1, 3'b000, 9'h1FC, 32'h12345677, 32'h00000000, 4'b0001, 32'h1FC, 32'h12345677};
        vecs[11] = '{1'b0, 3'b000, 9'h1FC, 32'h0,        32'h00000077, 4'b0000, 32'h1FC, 32'h0};
        vecs[12] = '{1'b1, 3'b001, 9'h1FE, 32'h0000F00D, 32'h00000000, 4'b1100, 32'h1FC, 32'hF00D0000};
        vecs[13] = '{1'b0, 3'b010, 9'h1FC, 32'h0,        32'hF00D0077, 4'b0000, 32'h1FC, 32'h0};
        vecs[14] = '{1'b1, 3'b100, 9'h011, 32'h000000FF, 32'h00000000, 4'b0010, 32'h010, 32'h0000FF00};
        vecs[15] = '{1'b0, 3'b001, 9'h010, 32'h0,        32'hFFFFFFEF, 4'b0000, 32'h010, 32'h0};
        vecs[16] = '{1'b0, 3'b101, 9'h010, 32'h0,        32'h0000FFEF, 4'b0000, 32'h010, 32'h0};

        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        rst_n = 1'b0; dev_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 9'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'h0, req_ready},  32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_rdata", resp_rdata,          32'h0);
        check("rst_resp_err",   {31'h0, resp_err},   32'h0);
        check("rst_mem_wr",     {28'h0, mem_wr},     32'h0);
        check("rst_mem_addr",   mem_addr,            32'h0);
        check("rst_mem_wdata",  mem_wdata,           32'h0);
        rst_n = 1'b1; dev_clear = 1'b0;

        // Directed aligned accesses (identical in both build variants)
        for (int i = 0; i < 17; i++) begin
            xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd);
            check("vec_rdata",    d_rd,                vecs[i].exp_rd);
            check("vec_err",      {31'h0, d_er},       32'h0);
            check("vec_latency",  d_lat,               32'd2);
            check("vec_wr_acc0",  {28'h0, wr_log[1]},  {28'h0, vecs[i].exp_wr});
            check("vec_addr_acc0", addr_log[1],        vecs[i].exp_maddr);
            check("vec_wr_done",  {28'h0, wr_log[2]},  32'h0);
            if (vecs[i].we) check("vec_wdata_acc0", wdat_log[1], vecs[i].exp_wdat);
        end
        @(negedge clk);
        check("rdata_hold_after_done", resp_rdata, 32'h0000FFEF);
        check("valid_one_cycle", {31'h0, resp_valid}, 32'h0);

        // Word-crossing accesses
        xact(1'b1, 3'b010, 9'h023, 32'h11223344);
        if (MISALIGN) begin
            check("split_sw_lat",    d_lat,              32'd3);
            check("split_sw_addr0",  addr_log[1],        32'h020);
            check("split_sw_wr0",    {28'h0, wr_log[1]}, 32'b1000);
            check("split_sw_wdat0",  wdat_log[1],        32'h44000000);
            check("split_sw_addr1",  addr_log[2],        32'h024);
            check("split_sw_wr1",    {28'h0, wr_log[2]}, 32'b0111);
            check("split_sw_wdat1",  wdat_log[2],        32'h00112233);
            check("split_sw_err",    {31'h0, d_er},      32'h0);
            xact(1'b0, 3'b010, 9'h023, 32'h0);
            check("split_lw_rdata",  d_rd,               32'h11223344);
            check("split_lw_lat",    d_lat,              32'd3);
            xact(1'b1, 3'b001, 9'h1FF, 32'h0000BEEF);
            check("wrap_sh_addr0",   addr_log[1],        32'h1FC);
            check("wrap_sh_wr0",     {28'h0, wr_log[1]}, 32'b1000);
            check("wrap_sh_addr1",   addr_log[2],        32'h000);
            check("wrap_sh_wr1",     {28'h0, wr_log[2]}, 32'b0001);
            xact(1'b0, 3'b001, 9'h1FF, 32'h0);
            check("wrap_lh_rdata",   d_rd,               32'hFFFFBEEF);
            check("wrap_lh_addr0",   addr_log[1],        32'h1FC);
            check("wrap_lh_addr1",   addr_log[2],        32'h000);
            check("wrap_lh_nowr",    {28'h0, wr_log[1] | wr_log[2]}, 32'h0);
        end else begin
            check("rej_sw_err",      {31'h0, d_er},      32'h1);
            check("rej_sw_lat",      d_lat,              32'd1);
            check("rej_sw_nowr",     {28'h0, wr_log[1]}, 32'h0);
            xact(1'b0, 3'b010, 9'h021, 32'h0);
            check("rej_lw_err",      {31'h0, d_er},      32'h1);
            check("rej_lw_rdata",    d_rd,               32'h0);
            check("rej_lw_lat",      d_lat,              32'd1);
            check("rej_lw_nowr",     {28'h0, wr_log[1]}, 32'h0);
            xact(1'b0, 3'b001, 9'h1FF, 32'h0);
            check("rej_lh_wrap_err", {31'h0, d_er},      32'h1);
        end

        // Reset in the middle of a store: no response, partial write at most, next request normal
        if (MISALIGN) begin
            rs_addr = 9'h0E2; rs_cyc = 2; rs_wr = 4'b0011; rs_maddr = 32'h0E4; rs_exp = 32'hF00D0000;
        end else begin
            rs_addr = 9'h0E0; rs_cyc = 1; rs_wr = 4'b1111; rs_maddr = 32'h0E0; rs_exp = 32'h0;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = rs_addr; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        for (int c = 1; c <= rs_cyc; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("rst_mid_pre_wr",   {28'h0, mem_wr}, {28'h0, rs_wr});
        check("rst_mid_pre_addr", mem_addr,        rs_maddr);
        rst_n = 1'b0;
        #1;
        check("rst_mid_wr",     {28'h0, mem_wr},     32'h0);
        check("rst_mid_ready",  {31'h0, req_ready},  32'h1);
        check("rst_mid_valid",  {31'h0, resp_valid}, 32'h0);
        check("rst_mid_addr",   mem_addr,            32'h0);
        check("rst_mid_rdata",  resp_rdata,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        check("rst_mid_no_resp", {31'h0, seen}, 32'h0);
        if (MISALIGN) begin
            ref_mem[9'h0E2] = 8'h0D;
            ref_mem[9'h0E3] = 8'hF0;
        end
        xact(1'b0, 3'b010, 9'h0E0, 32'h0);
        check("rst_after_lw0",  d_rd,  rs_exp);
        check("rst_after_lat",  d_lat, 32'd2);
        xact(1'b0, 3'b010, 9'h0E4, 32'h0);
        check("rst_after_lw1",  d_rd,  32'h0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       r_addr = 9'($urandom_range(0, 511));
                1:       r_addr = 9'(9'h1F8 + $urandom_range(0, 7));
                default: r_addr = 9'(9'h100 + $urandom_range(0, 63));
            endcase
            xact(r_we, r_f3, r_addr, $urandom);
            check("rand_rdata",   d_rd,          m_rd);
            check("rand_err",     {31'h0, d_er}, {31'h0, m_er});
            check("rand_latency", d_lat,         m_lat);
        end

        @(negedge clk);
        mism = 0;
        for (int i = 0; i < 512; i++) if (dev_mem[i] !== ref_mem[i]) mism++;
        check("mem_image_mismatches", mism, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
